// File: rtl/csr_counter_arbiter_if.sv
// CSR request/response bundle shared by the core EX stage and the debug port.
// master = requester side, slave = counter arbiter side.
interface csr_counter_arbiter_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/csr_counter_arbiter.sv
// 64-bit mcycle/minstret counters with round-robin CSR access from core and debug ports.
// Low-half reads snapshot the high half per requester so split 32-bit reads are atomic.
module csr_counter_arbiter #(
    parameter int unsigned CNT_W  = 64,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_ret,
    csr_counter_arbiter_if.slave  c_bus,
    csr_counter_arbiter_if.slave  d_bus
);

    localparam logic [ADDR_W-1:0] AddrMcycleLo   = ADDR_W'(12'hB00);
    localparam logic [ADDR_W-1:0] AddrMcycleHi   = ADDR_W'(12'hB80);
    localparam logic [ADDR_W-1:0] AddrMinstretLo = ADDR_W'(12'hB02);
    localparam logic [ADDR_W-1:0] AddrMinstretHi = ADDR_W'(12'hB82);
    localparam logic [ADDR_W-1:0] AddrCycleLo    = ADDR_W'(12'hC00);
    localparam logic [ADDR_W-1:0] AddrCycleHi    = ADDR_W'(12'hC80);
    localparam logic [ADDR_W-1:0] AddrInstretLo  = ADDR_W'(12'hC02);
    localparam logic [ADDR_W-1:0] AddrInstretHi  = ADDR_W'(12'hC82);
    localparam logic [ADDR_W-1:0] AddrInhibit    = ADDR_W'(12'h320);

    typedef enum logic [1:0] {StIdle, StGrant, StResp} state_e;

    state_e            state_q, state_d;
    logic              win_q, win_d;          // 0 = core, 1 = debug
    logic              rr_last_q, rr_last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  mcycle_q, mcycle_d;
    logic [CNT_W-1:0]  minstret_q, minstret_d;
    logic              inh_cy_q, inh_cy_d;
    logic              inh_ir_q, inh_ir_d;
    logic [31:0]       shadow_q [4];
    logic [31:0]       shadow_d [4];
    logic [3:0]        shadow_vld_q, shadow_vld_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    // Address decode of the latched access
    logic       hit, ro, is_cnt, is_inh, is_hi, cnt_sel, acc_err;
    logic [1:0] sh_idx;
    logic [CNT_W-1:0] cnt_val, cnt_new;
    logic [31:0] rd_val;

    always_comb begin
        hit     = 1'b1;
        ro      = 1'b0;
        is_cnt  = 1'b0;
        is_inh  = 1'b0;
        is_hi   = 1'b0;
        cnt_sel = 1'b0;
        case (addr_q)
            AddrMcycleLo:   is_cnt = 1'b1;
            AddrMcycleHi:   begin is_cnt = 1'b1; is_hi = 1'b1; end
            AddrMinstretLo: begin is_cnt = 1'b1; cnt_sel = 1'b1; end
            AddrMinstretHi: begin is_cnt = 1'b1; cnt_sel = 1'b1; is_hi = 1'b1; end
            AddrCycleLo:    begin is_cnt = 1'b1; ro = 1'b1; end
            AddrCycleHi:    begin is_cnt = 1'b1; ro = 1'b1; is_hi = 1'b1; end
            AddrInstretLo:  begin is_cnt = 1'b1; ro = 1'b1; cnt_sel = 1'b1; end
            AddrInstretHi:  begin is_cnt = 1'b1; ro = 1'b1; cnt_sel = 1'b1; is_hi = 1'b1; end
            AddrInhibit:    is_inh = 1'b1;
            default:        hit = 1'b0;
        endcase
        acc_err = !hit || (ro && we_q);
        sh_idx  = {win_q, cnt_sel};
        cnt_val = cnt_sel ? minstret_q : mcycle_q;
        cnt_new = is_hi ? {wdata_q, cnt_val[31:0]} : {cnt_val[CNT_W-1:32], wdata_q};
    end

    always_comb begin
        rd_val = '0;
        if (!acc_err && !we_q) begin
            if (is_inh) begin
                rd_val = {29'd0, inh_ir_q, 1'b0, inh_cy_q};
            end else if (!is_hi) begin
                rd_val = cnt_val[31:0];
            end else if (shadow_vld_q[sh_idx]) begin
                rd_val = shadow_q[sh_idx];
            end else begin
                rd_val = cnt_val[CNT_W-1:32];
            end
        end
    end

    // Counters, inhibit and shadows; a write replaces that counter's increment
    always_comb begin
        mcycle_d     = mcycle_q + {{(CNT_W-1){1'b0}}, !inh_cy_q};
        minstret_d   = minstret_q + {{(CNT_W-1){1'b0}}, inst_ret && !inh_ir_q};
        inh_cy_d     = inh_cy_q;
        inh_ir_d     = inh_ir_q;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        if (state_q == StGrant) begin
            rdata_d = rd_val;
            err_d   = acc_err;
            if (!acc_err) begin
                if (we_q && is_inh) begin
                    inh_cy_d = wdata_q[0];
                    inh_ir_d = wdata_q[2];
                end else if (we_q && is_cnt) begin
                    if (cnt_sel) minstret_d = cnt_new;
                    else         mcycle_d   = cnt_new;
                    shadow_vld_d[{1'b0, cnt_sel}] = 1'b0;
                    shadow_vld_d[{1'b1, cnt_sel}] = 1'b0;
                end else if (is_cnt) begin
                    if (!is_hi) begin
                        shadow_d[sh_idx]     = cnt_val[CNT_W-1:32];
                        shadow_vld_d[sh_idx] = 1'b1;
                    end else begin
                        shadow_vld_d[sh_idx] = 1'b0;
                    end
                end
            end
        end
    end

    // Access FSM
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        rr_last_d = rr_last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            StIdle: begin
                if (c_bus.req || d_bus.req) begin
                    win_d   = (c_bus.req && d_bus.req) ? !rr_last_q : d_bus.req;
                    we_d    = win_d ? d_bus.we    : c_bus.we;
                    addr_d  = win_d ? d_bus.addr  : c_bus.addr;
                    wdata_d = win_d ? d_bus.wdata : c_bus.wdata;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                rr_last_d = win_q;
                state_d   = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            win_q        <= 1'b0;
            rr_last_q    <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mcycle_q     <= '0;
            minstret_q   <= '0;
            inh_cy_q     <= 1'b0;
            inh_ir_q     <= 1'b0;
            shadow_vld_q <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            rr_last_q    <= rr_last_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mcycle_q     <= mcycle_d;
            minstret_q   <= minstret_d;
            inh_cy_q     <= inh_cy_d;
            inh_ir_q     <= inh_ir_d;
            shadow_vld_q <= shadow_vld_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            for (int i = 0; i < 4; i++) shadow_q[i] <= shadow_d[i];
        end
    end

    assign c_bus.gnt    = (state_q == StGrant) && !win_q;
    assign d_bus.gnt    = (state_q == StGrant) && win_q;
    assign c_bus.rvalid = (state_q == StResp) && !win_q;
    assign d_bus.rvalid = (state_q == StResp) && win_q;
    assign c_bus.rdata  = c_bus.rvalid ? rdata_q : 32'd0;
    assign d_bus.rdata  = d_bus.rvalid ? rdata_q : 32'd0;
    assign c_bus.err    = c_bus.rvalid && err_q;
    assign d_bus.err    = d_bus.rvalid && err_q;

endmodule

// File: tb/tb_csr_counter_arbiter.sv
// Bench for csr_counter_arbiter: table vectors, directed corner sequences and random
// traffic checked against a cycle-level counter/CSR model.
module tb_csr_counter_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic inst_ret = 1'b0;

    csr_counter_arbiter_if c_bus ();
    csr_counter_arbiter_if d_bus ();

    csr_counter_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .inst_ret (inst_ret),
        .c_bus    (c_bus),
        .d_bus    (d_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state: index 0 = mcycle, 1 = minstret; requester 0 = core, 1 = debug
    logic [63:0] m_cnt [2];
    logic [63:0] m_nxt [2];
    bit          m_inh [2];
    logic [31:0] m_sh  [2][2];
    bit          m_shv [2][2];
    bit          m_rr_last;

    bit          pend_v, pend_who, pend_we;
    logic [11:0] pend_addr;
    logic [31:0] pend_wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
    bit          ir_rand = 1'b0;

    logic [31:0] last_rd;
    bit          last_err;
    bit          first_w;

    typedef struct {
        bit          we;
        logic [11:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 64'd0;
            m_inh[i] = 1'b0;
            for (int j = 0; j < 2; j++) begin
                m_sh[i][j]  = 32'd0;
                m_shv[i][j] = 1'b0;
            end
        end
        m_rr_last = 1'b1;
        pend_v = 1'b0;
    endtask

    task automatic model_access();
        int k;
        bit hi, ro, ok;
        k = 0; hi = 0; ro = 0; ok = 1;
        case (pend_addr)
            12'hB00: k = 0;
            12'hB80: begin k = 0; hi = 1; end
            12'hB02: k = 1;
            12'hB82: begin k = 1; hi = 1; end
            12'hC00: begin k = 0; ro = 1; end
            12'hC80: begin k = 0; ro = 1; hi = 1; end
            12'hC02: begin k = 1; ro = 1; end
            12'hC82: begin k = 1; ro = 1; hi = 1; end
            12'h320: k = 2;
            default: ok = 0;
        endcase
        if (ro && pend_we) ok = 0;
        exp_err = !ok;
        exp_rd  = 32'd0;
        if (ok) begin
            if (k == 2) begin
                if (pend_we) begin
                    m_inh[0] = pend_wdata[0];
                    m_inh[1] = pend_wdata[2];
                end else begin
                    exp_rd = 32'(m_inh[0]) + 32'(m_inh[1]) * 4;
                end
            end else if (pend_we) begin
                if (hi) m_nxt[k] = {pend_wdata, m_cnt[k][31:0]};
                else    m_nxt[k] = {m_cnt[k][63:32], pend_wdata};
                m_shv[0][k] = 1'b0;
                m_shv[1][k] = 1'b0;
            end else if (!hi) begin
                exp_rd = m_cnt[k][31:0];
                m_sh[pend_who][k]  = m_cnt[k][63:32];
                m_shv[pend_who][k] = 1'b1;
            end else if (m_shv[pend_who][k]) begin
                exp_rd = m_sh[pend_who][k];
                m_shv[pend_who][k] = 1'b0;
            end else begin
                exp_rd = m_cnt[k][63:32];
            end
        end
        m_rr_last = pend_who;
        pend_v = 1'b0;
    endtask

    // Advance the model across the next rising edge, then step the DUT to it.
    task automatic tick();
        if (!rst) begin
            model_reset();
        end else begin
            m_nxt[0] = m_cnt[0] + (m_inh[0] ? 64'd0 : 64'd1);
            m_nxt[1] = m_cnt[1] + ((inst_ret && !m_inh[1]) ? 64'd1 : 64'd0);
            if (pend_v) model_access();
            m_cnt[0] = m_nxt[0];
            m_cnt[1] = m_nxt[1];
        end
        @(posedge clk);
        #1;
        if (ir_rand) inst_ret = 1'($urandom_range(0, 1));
    endtask

    task automatic run_reqs(input bit c_on, input bit c_we, input logic [11:0] c_addr,
                            input logic [31:0] c_wd, input bit d_on, input bit d_we,
                            input logic [11:0] d_addr, input logic [31:0] d_wd);
        bit pc, pd, w, first;
        pc = c_on; pd = d_on; first = 1'b1;
        c_bus.req = c_on; c_bus.we = c_we; c_bus.addr = c_addr; c_bus.wdata = c_wd;
        d_bus.req = d_on; d_bus.we = d_we; d_bus.addr = d_addr; d_bus.wdata = d_wd;
        while (pc || pd) begin
            w = (pc && pd) ? !m_rr_last : pd;
            if (first) first_w = w;
            first = 1'b0;
            tick();
            chk("c_gnt", c_bus.gnt, !w);
            chk("d_gnt", d_bus.gnt, w);
            chk("rvalid_in_grant", {c_bus.rvalid, d_bus.rvalid}, 2'b00);
            if (w) begin d_bus.req = 1'b0; pd = 1'b0; end
            else   begin c_bus.req = 1'b0; pc = 1'b0; end
            pend_v = 1'b1; pend_who = w;
            pend_we    = w ? d_we : c_we;
            pend_addr  = w ? d_addr : c_addr;
            pend_wdata = w ? d_wd : c_wd;
            tick();
            chk("c_rvalid", c_bus.rvalid, !w);
            chk("d_rvalid", d_bus.rvalid, w);
            chk("gnt_in_resp", {c_bus.gnt, d_bus.gnt}, 2'b00);
            last_rd  = w ? d_bus.rdata : c_bus.rdata;
            last_err = w ? d_bus.err : c_bus.err;
            chk("rdata", last_rd, exp_rd);
            chk("err", last_err, exp_err);
            chk("loser_rdata", w ? c_bus.rdata : d_bus.rdata, 32'd0);
            tick();
        end
    endtask

    task automatic rd(input bit who, input logic [11:0] a);
        if (who) run_reqs(0, 0, 12'h0, 32'h0, 1, 0, a, 32'h0);
        else     run_reqs(1, 0, a, 32'h0, 0, 0, 12'h0, 32'h0);
    endtask

    task automatic wr(input bit who, input logic [11:0] a, input logic [31:0] v);
        if (who) run_reqs(0, 0, 12'h0, 32'h0, 1, 1, a, v);
        else     run_reqs(1, 1, a, v, 0, 0, 12'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b, a2, b2;
        logic [11:0] addrs [12];
        vecs[0]  = '{1, 12'h320, 32'h0000_0005, 0, 32'h0};
        vecs[1]  = '{0, 12'h320, 32'h0,         0, 32'h5};
        vecs[2]  = '{1, 12'h320, 32'hFFFF_FFFF, 0, 32'h0};
        vecs[3]  = '{0, 12'h320, 32'h0,         0, 32'h5};
        vecs[4]  = '{1, 12'h320, 32'hFFFF_FFFA, 0, 32'h0};
        vecs[5]  = '{0, 12'h320, 32'h0,         0, 32'h0};
        vecs[6]  = '{0, 12'h123, 32'h0,         1, 32'h0};
        vecs[7]  = '{1, 12'hC00, 32'h1234_5678, 1, 32'h0};
        vecs[8]  = '{1, 12'hC82, 32'h1,         1, 32'h0};
        vecs[9]  = '{0, 12'hB01, 32'h0,         1, 32'h0};
        vecs[10] = '{1, 12'hB04, 32'h7,         1, 32'h0};
        vecs[11] = '{0, 12'hC01, 32'h0,         1, 32'h0};
        addrs = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                  12'hC02, 12'hC82, 12'h320, 12'h123, 12'hB01, 12'hC01};

        c_bus.req = 0; c_bus.we = 0; c_bus.addr = '0; c_bus.wdata = '0;
        d_bus.req = 0; d_bus.we = 0; d_bus.addr = '0; d_bus.wdata = '0;
        model_reset();
        #1;
        chk("reset_outputs", {c_bus.gnt, c_bus.rvalid, c_bus.err, d_bus.gnt, d_bus.rvalid,
                              d_bus.err}, 6'd0);
        chk("reset_rdata", {c_bus.rdata, d_bus.rdata}, 64'd0);
        tick();
        tick();
        rst = 1'b1;

        // Cycle count seen by the first core read after 10 idle cycles
        repeat (10) tick();
        rd(0, 12'hC00);
        chk("t1_cycle", last_rd, 32'd11);

        // Simultaneous requests: core wins the first tie, then round-robin
        do_reset();
        run_reqs(1, 0, 12'hB02, 0, 1, 0, 12'hB02, 0);
        chk("t2_first_core", first_w, 0);
        run_reqs(1, 0, 12'hB02, 0, 1, 0, 12'hB02, 0);
        chk("t2_repeat_core", first_w, 0);
        rd(0, 12'hB02);
        run_reqs(1, 0, 12'hB02, 0, 1, 0, 12'hB02, 0);
        chk("t2_alt_debug", first_w, 1);

        // Carry from low into high half after a debug write
        wr(1, 12'hB80, 32'h0);
        wr(1, 12'hB00, 32'hFFFF_FFFF);
        rd(1, 12'hB80);
        chk("t3_carry", last_rd, 32'd1);

        // High-half read returns the snapshot taken before the wrap
        wr(1, 12'hB80, 32'h0);
        wr(1, 12'hB00, 32'hFFFF_FFFC);
        rd(0, 12'hB00);
        chk("t4_lo", last_rd, 32'hFFFF_FFFE);
        rd(0, 12'hB80);
        chk("t4_hi_shadow", last_rd, 32'd0);

        // Inhibit freezes both counters
        wr(0, 12'h320, 32'h5);
        rd(0, 12'hB00); a = last_rd;
        rd(0, 12'hB02); b = last_rd;
        inst_ret = 1'b1;
        repeat (20) tick();
        inst_ret = 1'b0;
        rd(0, 12'hB00); a2 = last_rd;
        rd(0, 12'hB02); b2 = last_rd;
        chk("t5_cyc_frozen", a2, a);
        chk("t5_ins_frozen", b2, b);
        wr(0, 12'h320, 32'h0);
        rd(0, 12'hB00);
        chk("t5_resumed", last_rd != a, 1);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].we) wr(0, vecs[i].addr, vecs[i].wdata);
            else            rd(0, vecs[i].addr);
            chk($sformatf("tbl%0d_err", i), last_err, vecs[i].exp_err);
            chk($sformatf("tbl%0d_rd", i), last_rd, vecs[i].exp_rd);
        end

        // Error write leaves counter alone; reset in GRANT aborts the access
        wr(0, 12'hC00, 32'hDEAD_BEEF);
        chk("t6_err", last_err, 1);
        chk("t6_err_rd", last_rd, 32'd0);
        rd(0, 12'hC00);
        c_bus.req = 1'b1; c_bus.we = 1'b1; c_bus.addr = 12'hB00; c_bus.wdata = 32'h55;
        tick();
        chk("t6_gnt", c_bus.gnt, 1);
        c_bus.req = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("t6_async_gnt", c_bus.gnt, 0);
        tick();
        chk("t6_no_rvalid", c_bus.rvalid, 0);
        tick();
        rst = 1'b1;
        rd(0, 12'hC00);
        chk("t6_cnt_after_reset", last_rd, 32'd1);

        // Random traffic against the model
        ir_rand = 1'b1;
        for (int n = 0; n < 150; n++) begin
            bit co, dn;
            co = 1'($urandom_range(0, 1));
            dn = co ? 1'($urandom_range(0, 1)) : 1'b1;
            run_reqs(co, $urandom_range(0, 3) == 0, addrs[$urandom_range(0, 11)], $urandom,
                     dn, $urandom_range(0, 3) == 0, addrs[$urandom_range(0, 11)], $urandom);
            repeat ($urandom_range(0, 2)) tick();
        end
        ir_rand = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
